univ_reg: RTL and testbench

Parametrised successor to the single-bit ffd library cell. univ_reg is a WIDTH-bit universal register with:
- synchronous clear and preset;
- a global enable;
- a mode selector for hold, parallel load, shift, rotate and up/down count.

It is the standard storage and sequencing primitive for datapath and control blocks built on the cell library.

---
 rtl/univ_reg_defs.sv | 15 +
 rtl/univ_reg_next.sv | 51 +++++
 rtl/univ_reg.sv | 63 ++++++
 tb/tb_univ_reg.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/univ_reg_defs.sv
// Shared iMode encoding for univ_reg and any controller that drives it.
package univ_reg_defs;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_CNTU = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CNTD = 3'd7;

endpackage

// File: rtl/univ_reg_next.sv
// Combinational next-state and serial-out selection for univ_reg, indexed by mode.
module univ_reg_next
  import univ_reg_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_q,
  input  logic [WIDTH-1:0]  i_d,
  input  logic              i_ser_in,
  input  logic              i_ser_out,
  output logic [WIDTH-1:0]  o_q_next,
  output logic              o_ser_next
);

  // Each branch reads only the inputs that mode uses, so X on unused inputs cannot leak.
  always_comb begin
    o_q_next   = i_q;
    o_ser_next = i_ser_out;
    case (i_mode)
      MODE_HOLD: begin
        o_q_next   = i_q;
        o_ser_next = i_ser_out;
      end
      MODE_LOAD: o_q_next = i_d;
      MODE_SHL: begin
        o_q_next   = {i_q[WIDTH-2:0], i_ser_in};
        o_ser_next = i_q[WIDTH-1];
      end
      MODE_SHR: begin
        o_q_next   = {i_ser_in, i_q[WIDTH-1:1]};
        o_ser_next = i_q[0];
      end
      MODE_ROL: begin
        o_q_next   = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_ser_next = i_q[WIDTH-1];
      end
      MODE_ROR: begin
        o_q_next   = {i_q[0], i_q[WIDTH-1:1]};
        o_ser_next = i_q[0];
      end
      MODE_CNTU: o_q_next = i_q + {{(WIDTH-1){1'b0}}, 1'b1};
      MODE_CNTD: o_q_next = i_q - {{(WIDTH-1){1'b0}}, 1'b1};
      default: begin
        o_q_next   = i_q;
        o_ser_next = i_ser_out;
      end
    endcase
  end

endmodule

// File: rtl/univ_reg.sv
// WIDTH-bit universal register: clear/preset, enable, hold/load/shift/rotate/count.
module univ_reg
  import univ_reg_defs::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
  input  logic              iClk,
  input  logic              iClr,
  input  logic              iPre,
  input  logic              iEnb,
  input  logic [MODE_W-1:0] iMode,
  input  logic [WIDTH-1:0]  iD,
  input  logic              iSerIn,
  output logic [WIDTH-1:0]  oQp,
  output logic [WIDTH-1:0]  oQn,
  output logic              oSerOut,
  output logic              oTc
);

  logic [WIDTH-1:0] r_q;
  logic             r_ser_out;
  logic [WIDTH-1:0] w_q_next;
  logic             w_ser_next;
  logic             w_op_active;

  univ_reg_next #(.WIDTH(WIDTH)) u_next (
    .i_mode     (iMode),
    .i_q        (r_q),
    .i_d        (iD),
    .i_ser_in   (iSerIn),
    .i_ser_out  (r_ser_out),
    .o_q_next   (w_q_next),
    .o_ser_next (w_ser_next)
  );

  // Clear beats preset, preset beats enable-hold, which beats the mode operation.
  always_ff @(posedge iClk) begin
    if (iClr) begin
      r_q       <= CLR_VAL;
      r_ser_out <= 1'b0;
    end else if (iPre) begin
      r_q       <= PRE_VAL;
      r_ser_out <= 1'b0;
    end else if (iEnb) begin
      r_q       <= w_q_next;
      r_ser_out <= w_ser_next;
    end
  end

  assign w_op_active = iEnb & ~iClr & ~iPre;

  // High in the cycle before a counter wrap, for cascading stages.
  assign oTc = w_op_active &
               (((iMode == MODE_CNTU) && (r_q == {WIDTH{1'b1}})) ||
                ((iMode == MODE_CNTD) && (r_q == {WIDTH{1'b0}})));

  assign oQp     = r_q;
  assign oQn     = ~r_q;
  assign oSerOut = r_ser_out;

endmodule

// File: tb/tb_univ_reg.sv
// Directed bench for univ_reg (WIDTH=8, CLR_VAL=00, PRE_VAL=FF).
module tb_univ_reg;
  import univ_reg_defs::*;

  localparam int W = 8;

  logic          clk;
  logic          clr, pre, enb, ser_in;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [W-1:0]  qp, qn;
  logic          ser_out, tc;

  int n_checks = 0;
  int n_fail   = 0;

  univ_reg #(.WIDTH(W), .CLR_VAL(8'h00), .PRE_VAL(8'hFF)) dut (
    .iClk    (clk),
    .iClr    (clr),
    .iPre    (pre),
    .iEnb    (enb),
    .iMode   (mode),
    .iD      (d),
    .iSerIn  (ser_in),
    .oQp     (qp),
    .oQn     (qn),
    .oSerOut (ser_out),
    .oTc     (tc)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; pre = 1'b0; enb = 1'b0; mode = MODE_HOLD; d = '0; ser_in = 1'b0;

    // reset and priority
    tick(); tick();
    chk("rst_qp", qp, 8'h00);
    chk("rst_qn", qn, 8'hFF);
    chk("rst_ser", {7'd0, ser_out}, 8'h00);
    pre = 1'b1;
    tick();
    chk("clr_over_pre", qp, 8'h00);
    clr = 1'b0;
    #1;
    chk("tc_pre_gated", {7'd0, tc}, 8'h00);
    tick();
    chk("pre_qp", qp, 8'hFF);
    chk("pre_qn", qn, 8'h00);
    pre = 1'b0;

    // load / enable / hold
    enb = 1'b1; mode = MODE_LOAD; d = 8'hA5;
    tick();
    chk("load_a5", qp, 8'hA5);
    enb = 1'b0; d = 8'h3C;
    tick();
    chk("enb_off_hold", qp, 8'hA5);
    enb = 1'b1; mode = MODE_HOLD; d = 8'hxx; ser_in = 1'bx;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", qp, 8'hA5);
    end

    // shift
    mode = MODE_SHL; ser_in = 1'b1;
    tick();
    chk("shl_qp", qp, 8'h4B);
    chk("shl_ser", {7'd0, ser_out}, 8'h01);
    mode = MODE_SHR; ser_in = 1'b0;
    tick();
    chk("shr_qp", qp, 8'h25);
    chk("shr_ser", {7'd0, ser_out}, 8'h01);

    // rotate (serial and data inputs left X: must not reach the register)
    mode = MODE_LOAD; d = 8'h81;
    tick();
    chk("load_ser_kept", {7'd0, ser_out}, 8'h01);
    mode = MODE_ROL; d = 8'hxx; ser_in = 1'bx;
    tick();
    chk("rol_qp", qp, 8'h03);
    chk("rol_ser", {7'd0, ser_out}, 8'h01);
    mode = MODE_LOAD; d = 8'h81;
    tick();
    mode = MODE_ROR; d = 8'hxx;
    tick();
    chk("ror1_qp", qp, 8'hC0);
    for (int i = 1; i < 8; i++) tick();
    chk("ror8_qp", qp, 8'h81);
    chk("ror8_ser", {7'd0, ser_out}, 8'h01);

    // count wrap and terminal count
    mode = MODE_LOAD; d = 8'hFE; ser_in = 1'b0;
    tick();
    mode = MODE_CNTU;
    #1;
    chk("tc_at_fe", {7'd0, tc}, 8'h00);
    tick();
    chk("cntu_ff", qp, 8'hFF);
    chk("tc_at_ff", {7'd0, tc}, 8'h01);
    enb = 1'b0;
    #1;
    chk("tc_enb_gated", {7'd0, tc}, 8'h00);
    enb = 1'b1;
    tick();
    chk("cntu_wrap", qp, 8'h00);
    chk("tc_after_wrap", {7'd0, tc}, 8'h00);
    mode = MODE_CNTD;
    #1;
    chk("tc_cntd_00", {7'd0, tc}, 8'h01);
    tick();
    chk("cntd_wrap", qp, 8'hFF);
    chk("tc_cntd_ff", {7'd0, tc}, 8'h00);

    // clear mid-count
    mode = MODE_LOAD; d = 8'h10;
    tick();
    mode = MODE_CNTU;
    tick(); tick(); tick();
    chk("cnt_13", qp, 8'h13);
    clr = 1'b1;
    tick();
    chk("clr_mid_qp", qp, 8'h00);
    chk("clr_mid_ser", {7'd0, ser_out}, 8'h00);
    clr = 1'b0;
    tick();
    chk("resume_01", qp, 8'h01);
    tick();
    chk("resume_02", qp, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
